// File: rtl/spi_pkg.sv
// spi_pkg: shared SPI state encoding, field widths and command codes
package spi_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, BUSY = 2'd2, GAP = 2'd3} arb_state_t;
  localparam int SPI_WIDTH_W = 8;
  localparam int SPI_CMD_W = 2;
  localparam logic [SPI_CMD_W-1:0] SPI_CMD_READ = 2'd0;
  localparam logic [SPI_CMD_W-1:0] SPI_CMD_WRITE = 2'd1;
  localparam logic [SPI_CMD_W-1:0] SPI_CMD_XFER = 2'd2;
  localparam logic [SPI_CMD_W-1:0] SPI_CMD_CFG = 2'd3;
endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin picker, first set req above last_gnt wrapping to 0
module rr_pick #(
  parameter int N = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last_gnt,
  output logic [N-1:0]  win_oh,
  output logic [IW-1:0] win_idx,
  output logic          any
);
  logic [IW-1:0] lo, hi;
  logic hi_ok;
  // lowest set req overall and lowest set req strictly above last_gnt; the latter wins if present
  always_comb begin
    lo = '0;
    hi = '0;
    hi_ok = 1'b0;
    win_oh = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) lo = IW'(i);
      if (req[i] && IW'(i) > last_gnt) begin
        hi = IW'(i);
        hi_ok = 1'b1;
      end
    end
    win_idx = hi_ok ? hi : lo;
    any = |req;
    for (int i = 0; i < N; i++) win_oh[i] = any && win_idx == IW'(i);
  end
endmodule

// File: rtl/spi_req_arbiter.sv
// spi_req_arbiter: round-robin sharing of one SPI master with start strobe, watchdog and inter-transfer gap
module spi_req_arbiter
  import spi_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int GAP_CYCLES = 16,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                             sys_clk,
  input  logic                             sys_rst,
  input  logic [NUM_REQ-1:0]               req,
  input  logic [NUM_REQ*SPI_WIDTH_W-1:0]   req_width,
  input  logic [NUM_REQ*SPI_CMD_W-1:0]     req_cmd,
  output logic [NUM_REQ-1:0]               gnt,
  output logic [NUM_REQ-1:0]               done,
  output logic                             timeout_err,
  output logic                             busy,
  output logic                             start,
  output logic [SPI_WIDTH_W-1:0]           spi_width,
  output logic [SPI_CMD_W-1:0]             spi_cmd,
  input  logic                             out_flag
);
  localparam int IW = $clog2(NUM_REQ);
  localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int GW = GAP_CYCLES > 0 ? $clog2(GAP_CYCLES + 1) : 1;
  arb_state_t state, state_d;
  logic [IW-1:0] last_gnt, win_idx;
  logic [NUM_REQ-1:0] win_oh;
  logic any, wd_hit, fin, grant;
  logic [WW-1:0] wd_cnt;
  logic [GW-1:0] gap_cnt;
  rr_pick #(.N(NUM_REQ)) u_pick (
    .req     (req),
    .last_gnt(last_gnt),
    .win_oh  (win_oh),
    .win_idx (win_idx),
    .any     (any)
  );
  assign wd_hit = wd_cnt == WW'(TIMEOUT_CYCLES - 1);
  assign fin = state == BUSY && (out_flag || wd_hit);
  assign grant = state == IDLE && any;
  // next state: GAP holds for GAP_CYCLES+1 cycles including the done/err cycle, skipped when zero
  always_comb begin
    state_d = state;
    case (state)
      IDLE:    state_d = any ? ISSUE : IDLE;
      ISSUE:   state_d = BUSY;
      BUSY:    state_d = fin ? (GAP_CYCLES == 0 ? IDLE : GAP) : BUSY;
      GAP:     state_d = gap_cnt == GW'(GAP_CYCLES) ? IDLE : GAP;
      default: state_d = IDLE;
    endcase
  end
  // state register
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    state <= sys_rst ? IDLE : state_d;
  end
  // registered outputs, counters and the grant-time latch of width/cmd
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      gnt <= '0;
      done <= '0;
      timeout_err <= 1'b0;
      busy <= 1'b0;
      start <= 1'b0;
      spi_width <= '0;
      spi_cmd <= '0;
      last_gnt <= IW'(NUM_REQ - 1);
      wd_cnt <= '0;
      gap_cnt <= '0;
    end else begin
      start <= grant;
      busy <= state_d != IDLE;
      done <= (state == BUSY && out_flag) ? gnt : '0;
      timeout_err <= state == BUSY && !out_flag && wd_hit;
      wd_cnt <= state == BUSY ? wd_cnt + WW'(1) : '0;
      gap_cnt <= state == GAP ? gap_cnt + GW'(1) : '0;
      if (grant) begin
        gnt <= win_oh;
        last_gnt <= win_idx;
        spi_width <= req_width[{win_idx, 3'b000} +: SPI_WIDTH_W];
        spi_cmd <= req_cmd[{win_idx, 1'b0} +: SPI_CMD_W];
      end else if (fin) begin
        gnt <= '0;
      end
    end
  end
endmodule

// File: tb/tb_spi_req_arbiter.sv
// tb_spi_req_arbiter: directed checks of grant order, timing, watchdog, gap and reset
module tb_spi_req_arbiter;
  localparam int N = 4;
  localparam int G = 4;
  localparam int T = 100;
  logic sys_clk = 1'b0;
  logic sys_rst = 1'b1;
  logic [N-1:0] req = '0;
  logic [N*8-1:0] req_width = {8'h44, 8'h33, 8'd8, 8'h11};
  logic [N*2-1:0] req_cmd = {2'd3, 2'd2, 2'd1, 2'd0};
  logic out_flag = 1'b0;
  logic [N-1:0] gnt, done;
  logic timeout_err, busy, start;
  logic [7:0] spi_width;
  logic [1:0] spi_cmd;
  logic [7:0] wtab [N] = '{8'h11, 8'd8, 8'h33, 8'h44};
  int total = 0;
  int bad = 0;
  spi_req_arbiter #(.NUM_REQ(N), .GAP_CYCLES(G), .TIMEOUT_CYCLES(T)) dut (
    .sys_clk    (sys_clk),
    .sys_rst    (sys_rst),
    .req        (req),
    .req_width  (req_width),
    .req_cmd    (req_cmd),
    .gnt        (gnt),
    .done       (done),
    .timeout_err(timeout_err),
    .busy       (busy),
    .start      (start),
    .spi_width  (spi_width),
    .spi_cmd    (spi_cmd),
    .out_flag   (out_flag)
  );
  always #5 sys_clk = ~sys_clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge sys_clk);
      #1;
    end
  endtask
  task automatic chk_idle_outs(input string tag);
    chk({tag, "_gnt"}, 32'(gnt), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_err"}, 32'(timeout_err), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_start"}, 32'(start), 0);
    chk({tag, "_width"}, 32'(spi_width), 0);
    chk({tag, "_cmd"}, 32'(spi_cmd), 0);
  endtask
  initial begin
    tick(2);
    chk_idle_outs("reset");
    sys_rst = 1'b0;
    // single requester 1, completion 20 cycles after start
    req = 4'b0010;
    tick();
    chk("t1_gnt", 32'(gnt), 32'b0010);
    chk("t1_start", 32'(start), 1);
    chk("t1_width", 32'(spi_width), 8);
    chk("t1_cmd", 32'(spi_cmd), 1);
    tick();
    chk("t1_start_low", 32'(start), 0);
    tick(18);
    chk("t1_no_done_yet", 32'(done), 0);
    out_flag = 1'b1;
    tick();
    out_flag = 1'b0;
    req = '0;
    chk("t1_done", 32'(done), 32'b0010);
    chk("t1_gnt_drop", 32'(gnt), 0);
    tick();
    chk("t1_done_1cyc", 32'(done), 0);
    tick(G - 1);
    chk("t1_busy_in_gap", 32'(busy), 1);
    tick();
    chk("t1_busy_low", 32'(busy), 0);
    // all requesters held: rotation 0,1,2,3,0 from reset
    sys_rst = 1'b1;
    tick();
    sys_rst = 1'b0;
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk($sformatf("t2_gnt%0d", k), 32'(gnt), 32'(1 << (k % N)));
      chk($sformatf("t2_start%0d", k), 32'(start), 1);
      chk($sformatf("t2_width%0d", k), 32'(spi_width), 32'(wtab[k % N]));
      chk($sformatf("t2_cmd%0d", k), 32'(spi_cmd), 32'(k % N));
      tick();
      out_flag = 1'b1;
      tick();
      out_flag = 1'b0;
      chk($sformatf("t2_done%0d", k), 32'(done), 32'(1 << (k % N)));
      tick(G + 1);
      chk($sformatf("t2_gap_nostart%0d", k), 32'(start | busy), 0);
    end
    req = '0;
    // watchdog abort on BUSY cycle 100, then re-grant after the gap
    req = 4'b0100;
    tick();
    chk("t3_gnt", 32'(gnt), 32'b0100);
    tick(T);
    chk("t3_err_early", 32'(timeout_err), 0);
    tick();
    chk("t3_err", 32'(timeout_err), 1);
    chk("t3_no_done", 32'(done), 0);
    chk("t3_gnt_drop", 32'(gnt), 0);
    tick();
    chk("t3_err_1cyc", 32'(timeout_err), 0);
    tick(4);
    chk("t3_idle", 32'(busy | start), 0);
    tick();
    chk("t3_regrant", 32'(gnt), 32'b0100);
    chk("t3_regrant_start", 32'(start), 1);
    tick();
    out_flag = 1'b1;
    tick();
    out_flag = 1'b0;
    req = '0;
    chk("t3_done", 32'(done), 32'b0100);
    tick(G + 1);
    chk("t3_end_idle", 32'(busy), 0);
    // out_flag outside BUSY, then coincident with the watchdog limit
    out_flag = 1'b1;
    tick();
    out_flag = 1'b0;
    chk("t5_idle_flag", 32'({busy, done}), 0);
    req = 4'b0001;
    tick();
    chk("t5_gnt", 32'(gnt), 32'b0001);
    out_flag = 1'b1;
    tick();
    out_flag = 1'b0;
    chk("t5_issue_flag", 32'(done), 0);
    chk("t5_issue_busy", 32'(busy), 1);
    tick(T - 1);
    chk("t5_still_busy", 32'({busy, gnt}), 32'b10001);
    out_flag = 1'b1;
    tick();
    out_flag = 1'b0;
    chk("t5_coinc_done", 32'(done), 32'b0001);
    chk("t5_coinc_err", 32'(timeout_err), 0);
    out_flag = 1'b1;
    tick();
    out_flag = 1'b0;
    req = '0;
    chk("t5_gap_flag", 32'(done), 0);
    tick(3);
    chk("t5_gap_busy", 32'(busy), 1);
    tick();
    chk("t5_gap_end", 32'(busy), 0);
    // winner drops req and changes width mid-BUSY
    req = 4'b0010;
    tick();
    chk("t6_width", 32'(spi_width), 8);
    tick();
    req = '0;
    req_width[15:8] = 8'd16;
    tick(3);
    chk("t6_width_held", 32'(spi_width), 8);
    chk("t6_gnt_held", 32'(gnt), 32'b0010);
    out_flag = 1'b1;
    tick();
    out_flag = 1'b0;
    chk("t6_done", 32'(done), 32'b0010);
    req_width[15:8] = 8'd8;
    tick(G + 1);
    chk("t6_idle", 32'(busy), 0);
    // asynchronous reset during BUSY of requester 2
    req = 4'b0100;
    tick();
    chk("t4_gnt", 32'(gnt), 32'b0100);
    tick(2);
    #3;
    sys_rst = 1'b1;
    #1;
    chk_idle_outs("t4_async");
    req = 4'b1001;
    tick();
    sys_rst = 1'b0;
    tick();
    chk("t4_first", 32'(gnt), 32'b0001);
    chk("t4_first_start", 32'(start), 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
